// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory stage: opcodes, funct3 access sizes, the
// memory FSM states and small decode helpers.
package mem_access_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_NOP    = 7'b0000000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Combinational byte-lane steering: byte enables, store-data replication and
// load lane extraction with sign/zero extension.
module mem_access_lsu_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_load_raw[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_load_raw[15:8];
      2'd2:    w_byte = i_load_raw[23:16];
      2'd3:    w_byte = i_load_raw[31:24];
      default: w_byte = i_load_raw[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_load_raw[31:16] : i_load_raw[15:0];
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase
  end

  always_comb begin
    o_load_data = i_load_raw;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_load_raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RISC-V memory stage: loads/stores over a req/gnt/rvalid port, upstream stall,
// bus timeout. Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of truncating.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_out_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rs2_data_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_en_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  state_t      r_state, w_state_next;
  logic [31:0] r_addr, r_wdata, r_cnt, w_cnt_next;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_we;
  logic [31:0] r_wb_data, w_wb_data_next;
  logic [4:0]  r_wb_rd, w_wb_rd_next;
  logic        r_wb_en, w_wb_en_next;
  logic        r_misalign, w_misalign_next;
  logic        r_bus_err, w_bus_err_next;
  logic        w_stall, w_req, w_capture, w_timeout;

  logic        w_is_load, w_is_store, w_mem_op, w_misaligned;
  logic [31:0] w_addr_cap;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data;

  assign w_is_load  = (opcode_i == OPC_LOAD);
  assign w_is_store = (opcode_i == OPC_STORE);
  assign w_mem_op   = (w_is_load && load_f3_legal(funct3_i)) ||
                      (w_is_store && store_f3_legal(funct3_i));

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misaligned = ((funct3_i[1:0] == 2'b01) && alu_out_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (alu_out_i[1:0] != 2'b00));
  assign w_addr_cap   = alu_out_i;
`else
  assign w_misaligned = 1'b0;
  always_comb begin
    w_addr_cap = alu_out_i;
    case (funct3_i[1:0])
      2'b01:   w_addr_cap = {alu_out_i[31:1], 1'b0};
      2'b10:   w_addr_cap = {alu_out_i[31:2], 2'b00};
      default: w_addr_cap = alu_out_i;
    endcase
  end
`endif

  mem_access_lsu_align u_lsu_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_store_data (r_wdata),
    .i_load_raw   (dmem_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // Abort on the TIMEOUT_CYC-th REQ/WAIT cycle unless that cycle completes.
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == TIMEOUT_CYC - 32'd1);

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = 32'd0;
    w_stall         = 1'b0;
    w_req           = 1'b0;
    w_capture       = 1'b0;
    w_wb_data_next  = r_wb_data;
    w_wb_rd_next    = r_wb_rd;
    w_wb_en_next    = 1'b0;
    w_misalign_next = 1'b0;
    w_bus_err_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op && !w_misaligned) begin
          w_capture    = 1'b1;
          w_stall      = 1'b1;
          w_state_next = S_REQ;
        end else if (w_mem_op) begin
          w_misalign_next = 1'b1;
        end else if (!w_is_load && !w_is_store) begin
          w_wb_data_next = alu_out_i;
          w_wb_rd_next   = rd_i;
          w_wb_en_next   = writes_rd(opcode_i) && (rd_i != 5'd0);
        end
      end
      S_REQ: begin
        w_req = 1'b1;
        if (dmem_gnt_i && r_we) begin
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_state_next   = S_IDLE;
          w_bus_err_next = 1'b1;
        end else begin
          w_stall    = 1'b1;
          w_cnt_next = r_cnt + 32'd1;
          if (dmem_gnt_i) begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          w_state_next   = S_IDLE;
          w_wb_data_next = w_load_data;
          w_wb_rd_next   = r_rd;
          w_wb_en_next   = (r_rd != 5'd0);
        end else if (w_timeout) begin
          w_state_next   = S_IDLE;
          w_bus_err_next = 1'b1;
        end else begin
          w_stall    = 1'b1;
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 32'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
      r_rd       <= 5'd0;
      r_we       <= 1'b0;
      r_wb_data  <= 32'd0;
      r_wb_rd    <= 5'd0;
      r_wb_en    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_wb_data  <= w_wb_data_next;
      r_wb_rd    <= w_wb_rd_next;
      r_wb_en    <= w_wb_en_next;
      r_misalign <= w_misalign_next;
      r_bus_err  <= w_bus_err_next;
      if (w_capture) begin
        r_addr   <= w_addr_cap;
        r_wdata  <= rs2_data_i;
        r_funct3 <= funct3_i;
        r_rd     <= rd_i;
        r_we     <= w_is_store;
      end
    end
  end

  assign stall_o      = w_stall;
  assign dmem_req_o   = w_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = {r_addr[31:2], 2'b00};
  assign dmem_be_o    = w_be;
  assign dmem_wdata_o = w_wdata;
  assign wb_data_o    = r_wb_data;
  assign wb_rd_o      = r_wb_rd;
  assign wb_en_o      = r_wb_en;
  assign misalign_o   = r_misalign;
  assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table for non-memory ops, hand sequences
// for loads, stores, timeout (second instance, TIMEOUT_CYC=4) and reset mid-access.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_out;
  logic [6:0]  opcode, t_opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] rs2;
  logic        gnt, rvalid, t_gnt, t_rvalid;
  logic [31:0] rdata;

  logic        stall, req, we, wb_en, misalign, bus_err;
  logic [31:0] addr, wdata, wb_data;
  logic [3:0]  be;
  logic [4:0]  wb_rd;

  logic        t_stall, t_req, t_we, t_wb_en, t_misalign, t_bus_err;
  logic [31:0] t_addr, t_wdata, t_wb_data;
  logic [3:0]  t_be;
  logic [4:0]  t_wb_rd;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .alu_out_i(alu_out), .opcode_i(opcode),
    .funct3_i(funct3), .rd_i(rd), .rs2_data_i(rs2), .stall_o(stall),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
    .wb_en_o(wb_en), .misalign_o(misalign), .bus_err_o(bus_err)
  );

  mem_access #(.TIMEOUT_CYC(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .alu_out_i(alu_out), .opcode_i(t_opcode),
    .funct3_i(funct3), .rd_i(rd), .rs2_data_i(rs2), .stall_o(t_stall),
    .dmem_req_o(t_req), .dmem_we_o(t_we), .dmem_addr_o(t_addr), .dmem_be_o(t_be),
    .dmem_wdata_o(t_wdata), .dmem_gnt_i(t_gnt), .dmem_rvalid_i(t_rvalid),
    .dmem_rdata_i(rdata), .wb_data_o(t_wb_data), .wb_rd_o(t_wb_rd),
    .wb_en_o(t_wb_en), .misalign_o(t_misalign), .bus_err_o(t_bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        upd;
    logic        exp_en;
  } vec_t;

  vec_t vecs[11];

  task automatic store_seq(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int gnt_dly, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    @(negedge clk);
    opcode = OPC_STORE; funct3 = f3; alu_out = a; rs2 = d; rd = 5'd0;
    #1 check({name, " stall_issue"}, stall, 1);
    check({name, " req_idle"}, req, 0);
    @(posedge clk); #1;
    opcode = OPC_NOP;
    for (int i = 0; i < gnt_dly; i++) begin
      check({name, " stall_wait"}, stall, 1);
      @(posedge clk); #1;
    end
    check({name, " req"}, req, 1);
    check({name, " we"}, we, 1);
    check({name, " addr"}, addr, exp_addr);
    check({name, " be"}, be, exp_be);
    check({name, " wdata"}, wdata, exp_wdata);
    gnt = 1'b1;
    #1 check({name, " stall_gnt"}, stall, 0);
    @(posedge clk); #1;
    gnt = 1'b0;
    check({name, " req_done"}, req, 0);
    check({name, " wb_en"}, wb_en, 0);
    $display("store %s addr=%08h be=%b wdata=%08h", name, addr, be, wdata);
  endtask

  task automatic load_seq(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] r, input int gnt_dly, input int rv_dly,
                          input logic [3:0] exp_be, input logic [31:0] rd_word,
                          input logic [31:0] exp_data);
    @(negedge clk);
    opcode = OPC_LOAD; funct3 = f3; alu_out = a; rd = r;
    #1 check({name, " stall_issue"}, stall, 1);
    @(posedge clk); #1;
    opcode = OPC_NOP; rd = 5'd0; alu_out = 32'h5A5A5A5A;
    for (int i = 0; i < gnt_dly; i++) begin
      check({name, " req_hold"}, req, 1);
      check({name, " addr_hold"}, addr, {a[31:2], 2'b00});
      check({name, " stall_req"}, stall, 1);
      @(posedge clk); #1;
    end
    check({name, " req"}, req, 1);
    check({name, " we"}, we, 0);
    check({name, " be"}, be, exp_be);
    gnt = 1'b1;
    #1 check({name, " stall_gnt"}, stall, 1);
    @(posedge clk); #1;
    gnt = 1'b0;
    for (int i = 1; i < rv_dly; i++) begin
      check({name, " req_wait"}, req, 0);
      check({name, " stall_wait"}, stall, 1);
      check({name, " wb_en_wait"}, wb_en, 0);
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rdata = rd_word;
    #1 check({name, " stall_rvalid"}, stall, 0);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = 32'hDEADDEAD;
    check({name, " wb_data"}, wb_data, exp_data);
    check({name, " wb_rd"}, {27'd0, wb_rd}, {27'd0, r});
    check({name, " wb_en"}, wb_en, (r != 5'd0));
    $display("load %s addr=%08h wb_data=%08h wb_rd=%0d wb_en=%0b", name, a, wb_data, wb_rd, wb_en);
    @(posedge clk); #1;
    check({name, " wb_en_once"}, wb_en, 0);
  endtask

  initial begin
    rst_n = 1'b0; opcode = OPC_NOP; t_opcode = OPC_NOP; funct3 = 3'd0; rd = 5'd0;
    alu_out = 32'd0; rs2 = 32'd0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    t_gnt = 1'b0; t_rvalid = 1'b0;

    vecs[0]  = '{OPC_OP,     3'd0, 5'd5,  32'h00001234, 1'b1, 1'b1};
    vecs[1]  = '{OPC_OP_IMM, 3'd0, 5'd0,  32'hFFFF0000, 1'b1, 1'b0};
    vecs[2]  = '{OPC_LUI,    3'd0, 5'd31, 32'hABCD0000, 1'b1, 1'b1};
    vecs[3]  = '{OPC_AUIPC,  3'd0, 5'd1,  32'h80000004, 1'b1, 1'b1};
    vecs[4]  = '{OPC_JAL,    3'd0, 5'd2,  32'h00000108, 1'b1, 1'b1};
    vecs[5]  = '{OPC_JALR,   3'd0, 5'd0,  32'h00000010, 1'b1, 1'b0};
    vecs[6]  = '{OPC_NOP,    3'd0, 5'd9,  32'h00000077, 1'b1, 1'b0};
    vecs[7]  = '{7'b1100011, 3'd1, 5'd3,  32'h00000001, 1'b1, 1'b0};
    vecs[8]  = '{OPC_LOAD,   3'd3, 5'd6,  32'h00000040, 1'b0, 1'b0};
    vecs[9]  = '{OPC_STORE,  3'd4, 5'd7,  32'h00000044, 1'b0, 1'b0};
    vecs[10] = '{OPC_LOAD,   3'd6, 5'd8,  32'h00000048, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst wb_data", wb_data, 0);
    check("rst wb_rd", {27'd0, wb_rd}, 0);
    check("rst wb_en", wb_en, 0);
    check("rst misalign", misalign, 0);
    check("rst bus_err", bus_err, 0);
    check("rst req", req, 0);
    check("rst stall", stall, 0);
    $display("reset wb_en=%0b req=%0b stall=%0b", wb_en, req, stall);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      opcode = vecs[i].opc; funct3 = vecs[i].f3; rd = vecs[i].rd; alu_out = vecs[i].alu;
      #1 check($sformatf("vec%0d stall", i), stall, 0);
      check($sformatf("vec%0d req", i), req, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d wb_en", i), wb_en, vecs[i].exp_en);
      if (vecs[i].upd) begin
        check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].alu);
        check($sformatf("vec%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].rd});
      end
      $display("vec%0d opc=%b f3=%0d wb_data=%08h wb_rd=%0d wb_en=%0b",
               i, vecs[i].opc, vecs[i].f3, wb_data, wb_rd, wb_en);
    end

    // rvalid while idle must not disturb a plain ALU write-back
    @(negedge clk);
    opcode = OPC_OP; rd = 5'd4; alu_out = 32'h00000055; rvalid = 1'b1; rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rvalid = 1'b0;
    check("idle_rvalid wb_data", wb_data, 32'h00000055);
    $display("idle rvalid wb_data=%08h", wb_data);

    store_seq("SB", F3_B, 32'h00000103, 32'hAABBCCDD, 0, 32'h00000100, 4'b1000, 32'hDDDDDDDD);
    store_seq("SH", F3_H, 32'h00000202, 32'h11223344, 1, 32'h00000200, 4'b1100, 32'h33443344);

    load_seq("LB",  F3_B,  32'h00000102, 5'd10, 0, 1, 4'b0100, 32'h00800000, 32'hFFFFFF80);
    load_seq("LBU", F3_BU, 32'h00000102, 5'd11, 0, 1, 4'b0100, 32'h00800000, 32'h00000080);
    load_seq("LH",  F3_H,  32'h00000102, 5'd12, 0, 1, 4'b1100, 32'h80010000, 32'hFFFF8001);
    load_seq("LHU", F3_HU, 32'h00000100, 5'd13, 0, 1, 4'b0011, 32'h1234ABCD, 32'h0000ABCD);
    load_seq("LB1", F3_B,  32'h00000101, 5'd14, 0, 1, 4'b0010, 32'h00007F00, 32'h0000007F);
    load_seq("LWd", F3_W,  32'h00000200, 5'd7,  3, 2, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF);
    load_seq("LW0", F3_W,  32'h00000300, 5'd0,  0, 1, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    opcode = OPC_STORE; funct3 = F3_W; alu_out = 32'h00000102; rs2 = 32'h01020304;
    #1 check("SWmis stall", stall, 0);
    @(posedge clk); #1;
    opcode = OPC_NOP;
    check("SWmis misalign", misalign, 1);
    check("SWmis req", req, 0);
    check("SWmis wb_en", wb_en, 0);
    @(posedge clk); #1;
    check("SWmis pulse", misalign, 0);
    $display("SW misaligned trap misalign pulse seen");
`else
    store_seq("SWmis", F3_W, 32'h00000102, 32'h01020304, 0, 32'h00000100, 4'b1111, 32'h01020304);
    store_seq("SHmis", F3_H, 32'h00000103, 32'hAAAA5566, 0, 32'h00000100, 4'b1100, 32'h55665566);
    check("misalign tied", misalign, 0);
`endif

    // timeout on the TIMEOUT_CYC=4 instance: never granted
    @(negedge clk);
    t_opcode = OPC_LOAD; funct3 = F3_W; alu_out = 32'h00000300; rd = 5'd3;
    #1 check("TO stall_issue", t_stall, 1);
    @(posedge clk); #1;
    t_opcode = OPC_NOP;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("TO req c%0d", i), t_req, 1);
      check($sformatf("TO stall c%0d", i), t_stall, (i < 4));
      check($sformatf("TO bus_err c%0d", i), t_bus_err, 0);
      @(posedge clk); #1;
    end
    check("TO bus_err", t_bus_err, 1);
    check("TO req_drop", t_req, 0);
    check("TO wb_en", t_wb_en, 0);
    check("TO stall_idle", t_stall, 0);
    $display("timeout bus_err=%0b req=%0b", t_bus_err, t_req);
    @(posedge clk); #1;
    check("TO bus_err_pulse", t_bus_err, 0);

    // reset while a request is outstanding
    @(negedge clk);
    opcode = OPC_LOAD; funct3 = F3_W; alu_out = 32'h00000400; rd = 5'd8;
    @(posedge clk); #1;
    opcode = OPC_NOP;
    check("RST req_before", req, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("RST req", req, 0);
    check("RST stall", stall, 0);
    check("RST bus_err", bus_err, 0);
    check("RST wb_en", wb_en, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("RST req_after", req, 0);
    check("RST bus_err_after", bus_err, 0);
    $display("reset mid-access req=%0b bus_err=%0b", req, bus_err);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the five-stage RISC-V pipeline: consumes the EX/MEM pipeline register outputs, performs loads and stores over a request/grant/rvalid data-memory port, and registers the write-back result for WB. While a bus access is outstanding it holds the upstream pipeline with `stall_o`. It handles byte-lane steering, load sign/zero extension, misalignment detection and a bus timeout.

## Interface
- `TIMEOUT_CYC`, 255: bus cycles allowed in REQ+WAIT before abort; 0 disables the timeout.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `alu_out_i`  in  32  effective address (load/store) or ALU result (other ops).
- `opcode_i`  in  7  instruction opcode; nop encoding = bubble.
- `funct3_i`  in  3  access size/sign.
- `rd_i`  in  5  destination register.
- `rs2_data_i`  in  32  store data.
- `stall_o`  out  1  holds EX/MEM and all earlier stages.
- `dmem_req_o`  out  1  bus request.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  32  word address; bits [1:0] always 0.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  lane-replicated store data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  32  read data.
- `wb_data_o`  out  32  registered write-back value.
- `wb_rd_o`  out  5  registered destination.
- `wb_en_o`  out  1  registered write enable.
- `misalign_o`  out  1  one-cycle registered pulse, misaligned access.
- `bus_err_o`  out  1  one-cycle registered pulse, timeout abort.

## Operation
- FSM states IDLE, REQ, WAIT. Reset (rst_n low at a clock edge): state IDLE, every registered output 0, timeout counter 0.
- IDLE, non-memory op: `wb_data_o`<=`alu_out_i`, `wb_rd_o`<=`rd_i`, `wb_en_o`<=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR with rd≠0, else 0. No stall.
- IDLE, LOAD (0000011) or STORE (0100011) with legal funct3: capture address, data, funct3 and rd; go REQ; `stall_o`=1 combinationally in that cycle; `wb_en_o`<=0.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other value: treated as a bubble. No request, no stall, `wb_en_o`<=0.
- REQ: `dmem_req_o`=1 with stable addr/we/be/wdata until `dmem_gnt_i`. A store completes on grant and returns to IDLE. A load goes to WAIT.
- WAIT: `dmem_req_o`=0. On `dmem_rvalid_i`, the extended load data is registered with `wb_en_o`=(rd≠0), and the FSM returns to IDLE. rvalid in any other state is ignored.
- `stall_o`=1 in REQ and WAIT, except in the completing cycle (grant for a store, rvalid for a load), where it is 0 so upstream advances at that edge.
- Byte lanes:
  - SB: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - SW: be=1111.
  - Loads: be follows the same rule; data is selected by addr[1:0] and sign- or zero-extended per funct3.
- Timeout: the counter increments each cycle in REQ/WAIT and clears in IDLE. When it reaches `TIMEOUT_CYC` without completion: return to IDLE, drop the request, pulse `bus_err_o`, set `wb_en_o`<=0, and deassert `stall_o` in that cycle.

## Timing
- Non-memory op: result valid 1 cycle after input.
- Store, grant in first REQ cycle: 2 cycles occupancy.
- Load, grant then rvalid next cycle: 3 cycles occupancy; `wb_*` valid the cycle after rvalid.
- rvalid never sampled in the grant cycle.
- `wb_en_o` is 0 on every stalled cycle (bubble into WB).
- Reset mid-access: FSM returns to IDLE and the request drops at that edge. The access is lost, with no error pulse.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issue no request, pulse `misalign_o`, and set `wb_en_o`<=0, all from IDLE in 1 cycle with no stall.
- Undefined: address low bits are truncated to the access size (halfword: addr[0] forced 0; word: addr[1:0] forced 0). The access proceeds normally and `misalign_o` is tied 0.

## Structure
- Opcode, funct3 and nop encodings come from the shared define package.
- The FSM state encoding is added to that package.
- Sub-module `lsu_align` (combinational): byte enables, store-data replication, load extraction/extension.

## Test plan
- ADD, alu_out=0x1234, rd=5 -> next cycle wb_data=0x1234, wb_rd=5, wb_en=1, stall_o never 1.
- SB addr=0x103, rs2=0xAABBCCDD, gnt immediate -> be=1000, wdata=0xDDDDDDDD, addr=0x100, stall high 1 cycle, wb_en=0.
- LB addr=0x102, rdata=0x00800000 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x102, rdata=0x80010000 -> 0xFFFF8001.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later -> request and addr held stable, stall_o high until the rvalid cycle, wb_en pulses once.
- TIMEOUT_CYC=4, LW never granted -> bus_err_o pulses after 4 REQ cycles, wb_en=0, FSM back in IDLE.
- SW addr=0x102: with `MEM_MISALIGN_TRAP_EN` -> misalign_o=1, no dmem_req; without -> request at 0x100, be=1111.
